sb_bus_arbiter: RTL
===================

# sb_bus_arbiter

Round-robin arbiter for the shared snoopy bus: owns the single bus and grants it to one of NUM_MASTERS cache controllers at a time. Sequences each tenure through grant, transfer and release, and revokes the bus on snoop retry, on a missing start, or on a hold timeout. Sits between the per-cache bus interfaces and the snoopy-bus datapath that carries `Tdata_sb` packets.

## Interface
Parameters:
- NUM_MASTERS, 4: number of requesting cache controllers, 2..16.
- START_WAIT, 4: cycles the granted master has to assert start before the grant is revoked, 1..255.
- HOLD_MAX, 64: maximum BUSY cycles per tenure when the timeout feature is compiled in, 2..65535.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_MASTERS  level request per master; held until its tenure ends.
- start  in  NUM_MASTERS  one-cycle pulse; the master is driving its Start byte.
- done  in  NUM_MASTERS  one-cycle pulse; the master's End byte has been accepted.
- retry  in  1  one-cycle snoop-retry pulse from any snooper.
- gnt  out  NUM_MASTERS  one-hot-or-zero grant, registered.
- owner  out  $clog2(NUM_MASTERS)  index of the current or last owner.
- bus_busy  out  1  bus tenure in progress, including the release cycle.
- abort  out  1  one-cycle pulse; the current tenure was revoked.
- gnt_hdr  out  Theader  Type=SB_GRANT, Size=owner while gnt is non-zero; all zero otherwise.

## Operation
- FSM states are `SB_IDLE`, `SB_GRANT`, `SB_BUSY` and `SB_RELEASE`. The state register, pointer, counters and all outputs are registered.
- **Arbitration.** Round-robin from pointer `ptr`: the first requesting index at or after `ptr`, modulo NUM_MASTERS, wins.
- **SB_IDLE.** If any req is high, latch the winner into owner, set gnt[owner] and go to SB_GRANT.
- **SB_GRANT.** Conditions are checked in this order:
  - start[owner] goes to SB_BUSY.
  - req[owner] low goes to SB_RELEASE, without abort.
  - The wait counter reaching START_WAIT raises abort and goes to SB_RELEASE.
  - retry is ignored in this state.
- **SB_BUSY.** Conditions are checked in this order:
  - done[owner] goes to SB_RELEASE.
  - retry raises abort and goes to SB_RELEASE.
  - With the timeout feature, the hold counter reaching HOLD_MAX raises abort and goes to SB_RELEASE.
  - Simultaneous events: done beats retry, and retry beats timeout. When done wins, no abort is raised.
- **SB_RELEASE.** gnt is all zero and bus_busy stays 1 for this turnaround cycle. ptr <= (owner+1) mod NUM_MASTERS. In the same cycle the arbiter arbitrates from the new pointer: a winner goes to SB_GRANT, otherwise the FSM goes to SB_IDLE.
- start and done from non-owners are ignored. A retried or timed-out master loses priority, because the pointer advances past it.
- **Counters.** Both counters are cleared on every entry to their state and saturate; they never wrap.
- **Reset values.** Reset mid-tenure drops gnt at the next edge, with no abort pulse. After reset:
  - state = SB_IDLE, ptr = 0, owner = 0.
  - gnt = 0, bus_busy = 0, abort = 0, gnt_hdr = all zero.

## Timing
- Request to grant: req seen in SB_IDLE at cycle t gives gnt at t+1.
- done at t: gnt drops at t+1 (SB_RELEASE). The next grant is at t+2, so the minimum gap between tenures is one cycle.
- abort is asserted in the same cycle gnt drops, i.e. the SB_RELEASE cycle, and lasts exactly one cycle.
- START_WAIT timeout: gnt is high for START_WAIT cycles, then abort.
- HOLD_MAX timeout: at most HOLD_MAX cycles in SB_BUSY.

## Configuration
- Macro: `SB_ARB_TIMEOUT_EN`.
- Defined: the hold counter and HOLD_MAX timeout are present.
- Undefined: the hold counter is removed, and SB_BUSY exits only on done or retry. HOLD_MAX is still accepted but unused.
- The START_WAIT timeout is always present.

## Structure
- Shared package additions:
  - Packet Type constants SB_READ=8'h01, SB_WRITE=8'h02, SB_GRANT=8'h03, SB_RETRY=8'h04, SB_REQ_BUS=8'h05.
  - Enum `Tarb_state` (2 bits) for the four FSM states.
- gnt_hdr uses the existing `Theader` type.
- One sub-module: `sb_rr_picker`, a combinational round-robin picker with inputs req vector and ptr, and outputs valid and index. It is instantiated once.

## Test plan
- **Reset and single tenure.** Hold rst 2 cycles, then req=4'b0100; start[2] at cycle 3; done[2] at cycle 6.
  - Expect gnt=4'b0100 at cycle 2, and gnt_hdr Type=8'h03, Size=2.
  - Expect gnt=0 with bus_busy=1 at cycle 7; bus_busy=0 at cycle 8.
  - abort never pulses.
- **Fairness.** req=4'b1111 held, each owner completing 3 cycles after grant → grant order 0,1,2,3,0; exactly one idle gnt cycle between tenures.
- **Start timeout.** START_WAIT=4; req[1] high, never start → gnt[1] high 4 cycles, then abort pulses one cycle and gnt=0; the next grant goes to 2 if req[2] is high.
- **Retry vs done.**
  - retry while BUSY for owner 3 → abort=1, next owner 0.
  - retry and done[3] in the same cycle → abort=0, normal release.
- **Hold timeout.** HOLD_MAX=8, start but no done.
  - With `SB_ARB_TIMEOUT_EN`: abort after 8 BUSY cycles.
  - Without it: gnt held for 100 cycles, no abort.
- **Reset mid-tenure.** rst pulsed while SB_BUSY → gnt=0 and owner=0 at the next edge, no abort; the first grant after reset follows ptr=0.

Source files
------------

// File: rtl/sb_bus_arbiter_pkg.sv
// Shared snoopy-bus definitions: packet Type codes, packet header and arbiter FSM states.
package sb_bus_arbiter_pkg;

    // Packet Type codes carry a TYPE infix so they stay distinct from the FSM state names.
    localparam logic [7:0] SB_TYPE_READ    = 8'h01;
    localparam logic [7:0] SB_TYPE_WRITE   = 8'h02;
    localparam logic [7:0] SB_TYPE_GRANT   = 8'h03;
    localparam logic [7:0] SB_TYPE_RETRY   = 8'h04;
    localparam logic [7:0] SB_TYPE_REQ_BUS = 8'h05;

    typedef struct packed {
        logic [7:0] Type;
        logic [7:0] Size;
    } Theader;

    typedef enum logic [1:0] {
        SB_IDLE    = 2'd0,
        SB_GRANT   = 2'd1,
        SB_BUSY    = 2'd2,
        SB_RELEASE = 2'd3
    } Tarb_state;

endpackage

// File: rtl/sb_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index at or after i_ptr, modulo N.
module sb_rr_picker
    import sb_bus_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_index
);

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[(int'(i_ptr) + i) % N]) begin
                o_valid = 1'b1;
                o_index = IW'((int'(i_ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/sb_bus_arbiter.sv
// Round-robin snoopy-bus arbiter: grant / transfer / release with start, retry and hold revocation.
// Optional hold-timeout is compiled in with `define SB_ARB_TIMEOUT_EN.
module sb_bus_arbiter
    import sb_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int START_WAIT  = 4,
    parameter int HOLD_MAX    = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [NUM_MASTERS-1:0]         start,
    input  logic [NUM_MASTERS-1:0]         done,
    input  logic                           retry,
    output logic [NUM_MASTERS-1:0]         gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           bus_busy,
    output logic                           abort,
    output Theader                         gnt_hdr,
    output Tarb_state                      o_dbg_state
);

    localparam int IW = $clog2(NUM_MASTERS);

    Tarb_state              r_state, w_state_nxt;
    logic [IW-1:0]          r_ptr, w_ptr_nxt;
    logic [IW-1:0]          r_owner, w_owner_nxt;
    logic [IW-1:0]          w_ptr_inc, w_pick_ptr, w_pick_idx;
    logic                   w_pick_valid;
    logic                   w_abort_nxt;
    logic                   w_gnt_on;
    logic [7:0]             r_wait, w_wait_nxt;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic                   r_busy, r_abort;
    Theader                 r_hdr;

`ifdef SB_ARB_TIMEOUT_EN
    logic [15:0]            r_hold, w_hold_nxt;
`else
    logic                   w_unused_hold;
    assign w_unused_hold = ^16'(HOLD_MAX);
`endif

    assign w_ptr_inc  = (r_owner == IW'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;
    // The release cycle already arbitrates from the advanced pointer.
    assign w_pick_ptr = (r_state == SB_RELEASE) ? w_ptr_inc : r_ptr;

    sb_rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
        .i_req   (req),
        .i_ptr   (w_pick_ptr),
        .o_valid (w_pick_valid),
        .o_index (w_pick_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_abort_nxt = 1'b0;
        w_wait_nxt  = r_wait;
`ifdef SB_ARB_TIMEOUT_EN
        w_hold_nxt  = r_hold;
`endif
        case (r_state)
            SB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = SB_GRANT;
                    w_owner_nxt = w_pick_idx;
                    w_wait_nxt  = 8'd1;
                end
            end
            SB_GRANT: begin
                if (start[r_owner]) begin
                    w_state_nxt = SB_BUSY;
`ifdef SB_ARB_TIMEOUT_EN
                    w_hold_nxt  = 16'd1;
`endif
                end else if (!req[r_owner]) begin
                    w_state_nxt = SB_RELEASE;
                end else if (r_wait >= 8'(START_WAIT)) begin
                    w_state_nxt = SB_RELEASE;
                    w_abort_nxt = 1'b1;
                end else if (r_wait != 8'hFF) begin
                    w_wait_nxt  = r_wait + 8'd1;
                end
            end
            SB_BUSY: begin
                if (done[r_owner]) begin
                    w_state_nxt = SB_RELEASE;
                end else if (retry) begin
                    w_state_nxt = SB_RELEASE;
                    w_abort_nxt = 1'b1;
`ifdef SB_ARB_TIMEOUT_EN
                end else if (r_hold >= 16'(HOLD_MAX)) begin
                    w_state_nxt = SB_RELEASE;
                    w_abort_nxt = 1'b1;
                end else if (r_hold != 16'hFFFF) begin
                    w_hold_nxt  = r_hold + 16'd1;
`endif
                end
            end
            SB_RELEASE: begin
                w_ptr_nxt = w_ptr_inc;
                if (w_pick_valid) begin
                    w_state_nxt = SB_GRANT;
                    w_owner_nxt = w_pick_idx;
                    w_wait_nxt  = 8'd1;
                end else begin
                    w_state_nxt = SB_IDLE;
                end
            end
            default: w_state_nxt = SB_IDLE;
        endcase
    end

    assign w_gnt_on = (w_state_nxt == SB_GRANT) || (w_state_nxt == SB_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SB_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_wait  <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
            r_hdr   <= '0;
`ifdef SB_ARB_TIMEOUT_EN
            r_hold  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_wait  <= w_wait_nxt;
            r_gnt   <= w_gnt_on ? (NUM_MASTERS'(1) << w_owner_nxt) : '0;
            r_busy  <= (w_state_nxt != SB_IDLE);
            r_abort <= w_abort_nxt;
            r_hdr   <= w_gnt_on ? '{Type: SB_TYPE_GRANT, Size: 8'(w_owner_nxt)} : '0;
`ifdef SB_ARB_TIMEOUT_EN
            r_hold  <= w_hold_nxt;
`endif
        end
    end

    assign gnt         = r_gnt;
    assign owner       = r_owner;
    assign bus_busy    = r_busy;
    assign abort       = r_abort;
    assign gnt_hdr     = r_hdr;
    assign o_dbg_state = r_state;

endmodule
